// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier:
// FSM state encoding, Booth recode select codes for radix-2 and radix-4,
// and constant functions that size the iteration counter.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-2 recode of {Q[0], q_-1}; 00 and 11 add nothing
    localparam logic [1:0] R2_ADD = 2'b01;
    localparam logic [1:0] R2_SUB = 2'b10;

    // Radix-4 recode of {Q[1], Q[0], q_-1}; 000 and 111 add nothing
    localparam logic [2:0] R4_ADD1_A = 3'b001;
    localparam logic [2:0] R4_ADD1_B = 3'b010;
    localparam logic [2:0] R4_ADD2   = 3'b011;
    localparam logic [2:0] R4_SUB2   = 3'b100;
    localparam logic [2:0] R4_SUB1_A = 3'b101;
    localparam logic [2:0] R4_SUB1_B = 3'b110;

    // Number of Booth steps for an n-bit multiplier extended by one bit
    function automatic int iter_count(input int n, input int radix);
        if (radix == 4)
            return ((n + 1) + ((n + 1) % 2)) / 2;
        return n + 1;
    endfunction

    // Bits needed to count 0..k-1
    function automatic int clog2(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < k) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/booth_mn_seq_mult_if.sv
// Operand/result handshake bundle for booth_mn_seq_mult. The master side
// supplies operands and accepts the product; the multiplier is the slave.
interface booth_mn_seq_mult_if #(
    parameter int M = 32,
    parameter int N = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [M-1:0]     a;
    logic [N-1:0]     b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [M+N-1:0]   product;
    logic             busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_mn_seq_mult_step.sv
// One combinational Booth iteration: recode the low multiplier bits,
// add 0 / +-A (radix-2) or 0 / +-A / +-2A (radix-4) into P, then shift
// {P, Q, q_-1} arithmetically right by log2(RADIX).
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int AW    = 33,
    parameter int PW    = 34,
    parameter int QW    = 33,
    parameter int RADIX = 2
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [PW-1:0] p,
    input  logic        [QW-1:0] q,
    input  logic                 qm1,
    output logic signed [PW-1:0] p_nxt,
    output logic        [QW-1:0] q_nxt,
    output logic                 qm1_nxt
);
    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   a_neg;
    logic signed [PW-1:0]   p_sum;
    logic signed [PW+QW:0]  shift_in;
    logic signed [PW+QW:0]  shift_out;

    assign a_ext    = {{(PW-AW){a[AW-1]}}, a};
    assign a_neg    = ~a_ext + PW'(1);
    assign shift_in = {p_sum, q, qm1};
    assign {p_nxt, q_nxt, qm1_nxt} = shift_out;

    generate
        if (RADIX == 4) begin : g_radix4
            logic signed [PW-1:0] a2;
            logic signed [PW-1:0] a2_neg;
            assign a2     = a_ext <<< 1;
            assign a2_neg = ~a2 + PW'(1);

            // Select 0, +-A or +-2A from the overlapping bit triplet
            always_comb begin
                p_sum = p;
                case ({q[1], q[0], qm1})
                    R4_ADD1_A, R4_ADD1_B: p_sum = p + a_ext;
                    R4_ADD2:              p_sum = p + a2;
                    R4_SUB2:              p_sum = p + a2_neg;
                    R4_SUB1_A, R4_SUB1_B: p_sum = p + a_neg;
                    default:              p_sum = p;
                endcase
            end
            assign shift_out = shift_in >>> 2;
        end else begin : g_radix2
            // Select 0 or +-A from the current bit pair
            always_comb begin
                p_sum = p;
                case ({q[0], qm1})
                    R2_ADD:  p_sum = p + a_ext;
                    R2_SUB:  p_sum = p + a_neg;
                    default: p_sum = p;
                endcase
            end
            assign shift_out = shift_in >>> 1;
        end
    endgenerate

endmodule

// File: rtl/booth_mn_seq_mult.sv
// Iterative M x N Booth multiplier with valid/ready handshakes on both
// sides and a per-operation signed/unsigned mode. One Booth step is reused
// for K cycles; the result is held until the consumer takes it.
// Build option: define BOOTH_MULT_RADIX4_EN for radix-4 recoding
// (about half the iterations); products are identical either way.
module booth_mn_seq_mult
    import booth_mult_pkg::*;
#(
    parameter int M = 32,
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_mn_seq_mult_if.slave  bus
);
`ifdef BOOTH_MULT_RADIX4_EN
    localparam int RADIX = 4;
`else
    localparam int RADIX = 2;
`endif
    localparam int K  = iter_count(N, RADIX);
    // Radix-4 consumes two multiplier bits per step, so Q is padded to even
    localparam int QW = (RADIX == 4) ? 2 * K : N + 1;
    // One guard bit beyond the extended multiplicand, plus one more for 2A
    localparam int PW = M + 1 + RADIX / 2;
    localparam int CW = clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_t                 state, state_nxt;
    logic signed [M:0]      a_reg;
    logic signed [PW-1:0]   p_reg;
    logic        [QW-1:0]   q_reg;
    logic                   qm1_reg;
    logic        [CW-1:0]   cnt;
    logic        [M+N-1:0]  product_reg;

    logic signed [PW-1:0]   p_nxt;
    logic        [QW-1:0]   q_nxt;
    logic                   qm1_nxt;
    logic        [PW+QW-1:0] pq_nxt;
    logic                   unused_hi;
    logic                   accept;
    logic                   sext;

    assign accept    = bus.in_valid && (state == IDLE);
    assign sext      = bus.is_signed;
    assign pq_nxt    = {p_nxt, q_nxt};
    // Bits above M+N are only extension of the exact product
    assign unused_hi = ^pq_nxt[PW+QW-1:M+N];

    booth_step #(
        .AW    (M + 1),
        .PW    (PW),
        .QW    (QW),
        .RADIX (RADIX)
    ) u_step (
        .a       (a_reg),
        .p       (p_reg),
        .q       (q_reg),
        .qm1     (qm1_reg),
        .p_nxt   (p_nxt),
        .q_nxt   (q_nxt),
        .qm1_nxt (qm1_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept in IDLE, iterate in RUN, hold result in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)          state_nxt = RUN;
            RUN:     if (cnt == LAST)     state_nxt = DONE;
            DONE:    if (bus.out_ready)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == RUN) || (state == DONE);
        bus.product   = product_reg;
    end

    // Operand load, Booth iteration and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            cnt         <= '0;
            product_reg <= '0;
        end else if (accept) begin
            a_reg   <= {sext & bus.a[M-1], bus.a};
            q_reg   <= {{(QW-N){sext & bus.b[N-1]}}, bus.b};
            p_reg   <= '0;
            qm1_reg <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            p_reg   <= p_nxt;
            q_reg   <= q_nxt;
            qm1_reg <= qm1_nxt;
            if (cnt == LAST) begin
                cnt         <= '0;
                product_reg <= pq_nxt[M+N-1:0];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_booth_mn_seq_mult.sv
// Self-checking bench for booth_mn_seq_mult: a 32x32 and an 8x5 instance,
// directed edge operands plus random operands, compared against plain
// integer multiplication, with latency, backpressure and async reset checks.
module tb_booth_mn_seq_mult;

`ifdef BOOTH_MULT_RADIX4_EN
    localparam int K32 = 17;
    localparam int K8  = 3;
`else
    localparam int K32 = 33;
    localparam int K8  = 6;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    booth_mn_seq_mult_if #(.M(32), .N(32)) bif ();
    booth_mn_seq_mult_if #(.M(8),  .N(5))  sif ();

    booth_mn_seq_mult #(.M(32), .N(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    booth_mn_seq_mult #(.M(8), .N(5)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] x, y;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
            return x * y;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [12:0] ref8(input logic [7:0] a, input logic [4:0] b, input logic s);
        logic signed [63:0] x, y;
        logic        [63:0] r;
        x = s ? 64'($signed(a)) : {56'b0, a};
        y = s ? 64'($signed(b)) : {59'b0, b};
        r = x * y;
        return r[12:0];
    endfunction

    // Called #1 after a clock edge with the 32-bit DUT idle
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int lat;
        logic [63:0] exp;
        exp = ref32(a, b, s);
        bif.a = a; bif.b = b; bif.is_signed = s;
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        check({tag, "_in_ready"}, 64'(bif.in_ready), 64'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.is_signed = ~s;
        bif.a = $urandom; bif.b = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bif.out_valid && lat < 300);
        check({tag, "_lat"}, 64'(lat), 64'(K32));
        check({tag, "_prod"}, bif.product, exp);
        @(posedge clk); #1;
        check({tag, "_idle"}, {62'b0, bif.in_ready, bif.out_valid}, 64'd2);
        check({tag, "_hold"}, bif.product, exp);
    endtask

    task automatic op8(input logic [7:0] a, input logic [4:0] b, input logic s, input string tag);
        int lat;
        logic [12:0] exp;
        exp = ref8(a, b, s);
        sif.a = a; sif.b = b; sif.is_signed = s;
        sif.in_valid = 1'b1; sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        sif.is_signed = ~s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!sif.out_valid && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(K8));
        check({tag, "_prod"}, 64'(sif.product), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int spurious;
        logic [63:0] exp1, exp2;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bif.in_valid = 1'b0; bif.out_ready = 1'b1; bif.a = '0; bif.b = '0; bif.is_signed = 1'b0;
        sif.in_valid = 1'b0; sif.out_ready = 1'b1; sif.a = '0; sif.b = '0; sif.is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check("rst_busy", 64'(bif.busy), 64'd0);
        check("rst_product", bif.product, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(bif.in_ready), 64'd1);

        // Directed operands
        op32(32'hFFFFFFFD, 32'd7, 1'b1, "neg3x7");
        check("neg3x7_const", bif.product, 64'hFFFFFFFFFFFFFFEB);
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "ones_u");
        check("ones_u_const", bif.product, 64'hFFFFFFFE00000001);
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "ones_s");
        op32(32'h80000000, 32'h80000000, 1'b1, "minmin_s");
        check("minmin_const", bif.product, 64'h4000000000000000);
        op32(32'h80000000, 32'd2, 1'b0, "min_x2_u");
        op32(32'd0, 32'h12345678, 1'b1, "zero_a");
        op32(32'h9ABCDEF0, 32'd0, 1'b0, "zero_b");

        op8(8'h80, 5'h10, 1'b1, "s8_min");
        check("s8_min_const", 64'(sif.product), 64'h0800);
        op8(8'hFF, 5'h1F, 1'b0, "u8_ones");
        check("u8_ones_const", 64'(sif.product), 64'h1EE1);
        op8(8'h80, 5'h10, 1'b0, "u8_min");

        // Random operands, random mode
        for (int i = 0; i < 16; i++)
            op32($urandom, $urandom, 1'($urandom_range(0, 1)), "rand32");
        for (int i = 0; i < 12; i++)
            op8(8'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), "rand8");

        // Backpressure: hold result while a second request waits
        exp1 = ref32(32'd123456, 32'hFFFFFF00, 1'b1);
        exp2 = ref32(32'hDEADBEEF, 32'h00C0FFEE, 1'b0);
        bif.a = 32'd123456; bif.b = 32'hFFFFFF00; bif.is_signed = 1'b1;
        bif.in_valid = 1'b1; bif.out_ready = 1'b0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bif.out_valid && lat < 300);
        check("bp_lat", 64'(lat), 64'(K32));
        for (int i = 0; i < 5; i++) begin
            bif.a = 32'hDEADBEEF; bif.b = 32'h00C0FFEE; bif.is_signed = 1'b0;
            bif.in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_stall", {bif.product, 2'b0} | {64'b0, bif.out_valid, bif.in_ready},
                  {exp1, 2'b0} | 66'b10);
        end
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'b0, bif.in_ready, bif.out_valid}, 64'd2);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        check("bp_second_busy", 64'(bif.busy), 64'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bif.out_valid && lat < 300);
        check("bp_second_lat", 64'(lat), 64'(K32));
        check("bp_second_prod", bif.product, exp2);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an operation
        bif.a = 32'h7FFFFFFF; bif.b = 32'h7FFFFFFF; bif.is_signed = 1'b1;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bif.busy), 64'd0);
        check("arst_out_valid", 64'(bif.out_valid), 64'd0);
        check("arst_product", bif.product, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < K32 + 5; i++) begin
            @(posedge clk); #1;
            if (bif.out_valid || bif.busy) spurious++;
        end
        check("arst_no_spurious", 64'(spurious), 64'd0);
        op32(32'd5, 32'd6, 1'b0, "post_rst");
        check("post_rst_const", bif.product, 64'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mn_seq_mult.md
Name: booth_mn_seq_mult

Overview:
Iterative, parametrised M x N Booth multiplier. It replaces the fully unrolled 32x32 combinational array with one shared Booth step reused over multiple cycles, and wraps it in a valid/ready handshake on both input and output. It adds a per-operation signed/unsigned mode and non-square operand widths. It sits in the datapath wherever a multi-cycle multiply is acceptable in exchange for area.

Parameters:
M, 32, multiplicand (a) width in bits, M >= 2
N, 32, multiplier (b) width in bits, N >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode are valid
in_ready  output  1  block can accept an operation; equals (state == IDLE)
a  input  M  multiplicand
b  input  N  multiplier
is_signed  input  1  1 = both operands two's complement; 0 = both unsigned
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts the product
product  output  M+N  a*b, full width, no truncation
busy  output  1  high in RUN and DONE

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state = IDLE, product = 0, out_valid = 0, busy = 0, iteration counter = 0, internal registers = 0. in_ready = 1 once rst_n is high.
- States:
  - IDLE: on in_valid && in_ready, go to RUN and load the operand registers.
  - RUN: go to DONE on the edge that completes the last iteration.
  - DONE: go to IDLE on out_valid && out_ready.
- Operand extension on load:
  - A = a extended to M+1 bits (sign-extended if is_signed, else zero-extended).
  - Q = b extended to N+1 bits by the same rule.
  - Accumulator P (M+2 bits) = 0; Booth bit q_-1 = 0.
  - is_signed is captured at load; later changes have no effect.
- Radix-2 step (one per cycle in RUN):
  - Recode {Q[0], q_-1}: 01 -> P += A; 10 -> P -= A (two's-complement add of ~A+1); 00/11 -> no add.
  - Then arithmetic-shift {P, Q, q_-1} right by 1.
- Iteration count K = N+1. The counter runs 0..K-1 and wraps to 0 on entry to DONE.
- Result: product = low M+N bits of the {P, Q} concatenation after K steps. This is exact for both modes because the extended operands cannot overflow M+N+2 bits.
- Latency: acceptance edge t0; steps on edges t0+1 .. t0+K; out_valid rises after edge t0+K. With defaults, out_valid is high 33 cycles after acceptance.
- product is registered, is stable while out_valid = 1, and holds its last value after the output handshake until the next result.
- Output backpressure: DONE persists indefinitely while out_ready = 0. No new operation is accepted in RUN or DONE (in_ready = 0); in_valid is ignored there.
- out_valid && out_ready returns to IDLE; in_ready is high the following cycle. No overlap of operations, so peak throughput is one result per K+2 cycles.
- Reset asserted mid-RUN or in DONE: immediate return to reset values, partial result discarded, and no out_valid pulse after release.
- Edge operands that must be exact:
  - Signed: most-negative x most-negative.
  - Unsigned: all-ones x all-ones.
  - Zero in either operand: product = 0 after full latency (no early termination).

Optional Feature:
BOOTH_MULT_RADIX4_EN
- Defined: radix-4 recoding of triplets {Q[1], Q[0], q_-1} selecting 0, +/-A, +/-2A. P is widened to M+3 bits; shift by 2 per step. Q is sign/zero-extended to W = N+1 rounded up to even, and K = W/2 (defaults: K = 17, out_valid 17 cycles after acceptance).
- Undefined: radix-2 as above, K = N+1.
- Product values are identical in both builds; only latency differs.

Decomposition:
- Package booth_mult_pkg:
  - state enum (IDLE, RUN, DONE)
  - Booth recode constants for radix-2 and radix-4 select codes
  - constant function iter_count(N, radix) returning K
  - counter width function clog2(K)
- Sub-module booth_step: combinational single recode + add/subtract + arithmetic shift. It takes P, Q, q_-1 and A, returns the next P, Q, q_-1, and is generated for radix 2 or 4 under the macro. The top holds the FSM, registers and handshake.

Test Plan:
- M=N=32, signed, a=-3 (0xFFFFFFFD), b=7 -> product 0xFFFFFFFFFFFFFFEB; out_valid exactly 33 cycles after acceptance (17 with BOOTH_MULT_RADIX4_EN).
- M=N=32, unsigned, a=b=0xFFFFFFFF -> 0xFFFFFFFE00000001. Same operands, signed -> 0x0000000000000001.
- M=N=32, signed, a=b=0x80000000 -> 0x4000000000000000. Unsigned a=0x80000000, b=2 -> 0x0000000100000000.
- M=8, N=5:
  - signed a=0x80, b=0x10 -> product 13'h0800
  - unsigned a=0xFF, b=0x1F -> 13'h1EE1
  - latency 6 cycles radix-2, 3 cycles radix-4
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands -> product stable, in_ready=0, second operation not accepted. Release -> IDLE, then the second operation is accepted and its correct product follows.
- Drop rst_n asynchronously mid-RUN (iteration 10) -> outputs return to reset values with no clock edge. After release, no spurious out_valid, and a fresh 5*6 operation yields 30.
